arbitro_somador: RTL

// Shares one signed adder with Z/N/P flag generation between two requesters.

---
 rtl/arbitro_somador_pkg.sv | 25 ++
 rtl/arbitro_somador_if.sv | 53 +++++
 rtl/arbitro_somador_flags.sv | 33 +++
 rtl/arbitro_somador.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/arbitro_somador_pkg.sv
// ---------------------------------------------------------------------------
// somador_pkg
// Shared types and defaults for the two-requester shared adder.
//   estado_t  : controller states (IDLE, CALC, HOLD)
//   WIDTH_DEF : default operand/result width
//   req_id_t  : requester identifier (0 or 1)
//   other_req : returns the requester that is not the argument
// ---------------------------------------------------------------------------
package somador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } estado_t;

    localparam int WIDTH_DEF = 8;

    typedef logic req_id_t;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/arbitro_somador_if.sv
// ---------------------------------------------------------------------------
// arbitro_somador_if
// Bundles the two request channels and the result channel of the shared adder.
//   reqX_valid/a/b : requester X operation (driven by clients)
//   reqX_ready     : requester X accepted this cycle (driven by arbiter)
//   res_valid/res_*: registered result and flags (driven by arbiter)
//   res_ready      : consumer takes the result (driven by consumer)
// Modports: master = client/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface arbitro_somador_if
    import somador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             res_valid;
    logic             res_ready;
    logic             res_id;
    logic [WIDTH-1:0] res_s;
    logic             res_z;
    logic             res_n;
    logic             res_p;
    logic             res_v;

    modport master (
        output req0_valid, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_a, req1_b,
        input  req1_ready,
        input  res_valid, res_id, res_s, res_z, res_n, res_p, res_v,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_a, req1_b,
        output req1_ready,
        output res_valid, res_id, res_s, res_z, res_n, res_p, res_v,
        input  res_ready
    );

endinterface

// File: rtl/arbitro_somador_flags.sv
// ---------------------------------------------------------------------------
// somador_flags
// Purely combinational two's-complement adder with result flags.
//   a, b : signed operands
//   s    : a + b modulo 2^WIDTH (carry-out discarded)
//   z    : s is zero
//   n    : sign bit of s
//   p    : s is even
//   v    : signed overflow (operands agree in sign, sum does not)
// ---------------------------------------------------------------------------
module somador_flags
    import somador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             z,
    output logic             n,
    output logic             p,
    output logic             v
);

    always_comb begin
        s = a + b;
        z = (s == '0);
        n = s[WIDTH-1];
        p = ~s[0];
        v = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/arbitro_somador.sv
// ---------------------------------------------------------------------------
// arbitro_somador
// Round-robin arbiter sharing one signed adder between two requesters.
// Captures the granted operands, computes sum and flags one cycle later and
// holds the registered result until the consumer takes it.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : request/result channels (slave side of arbitro_somador_if)
//
// state | meaning
// IDLE  | waiting for a request; grants one and latches its operands
// CALC  | latched operands on the adder; result registered on this edge
// HOLD  | result valid, waiting for res_ready
// ---------------------------------------------------------------------------
module arbitro_somador
    import somador_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input logic              clk,
    input logic              reset,
    arbitro_somador_if.slave bus
);

    estado_t          state;
    estado_t          state_nxt;

    req_id_t          prio;
    req_id_t          gnt_id;
    logic             gnt_valid;

    req_id_t          op_id;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    logic [WIDTH-1:0] sum_s;
    logic             sum_z;
    logic             sum_n;
    logic             sum_p;
    logic             sum_v;

    logic             res_valid_q;
    req_id_t          res_id_q;
    logic [WIDTH-1:0] res_s_q;
    logic             res_z_q;
    logic             res_n_q;
    logic             res_p_q;
    logic             res_v_q;

    somador_flags #(.WIDTH(WIDTH)) u_somador (
        .a (op_a),
        .b (op_b),
        .s (sum_s),
        .z (sum_z),
        .n (sum_n),
        .p (sum_p),
        .v (sum_v)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_valid) state_nxt = CALC;
            CALC:    state_nxt = HOLD;
            HOLD:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant only in IDLE; a lone requester wins outright, contention goes to prio.
    // Ready is suppressed while reset is held so no accept is signalled then.
    always_comb begin
        gnt_valid = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_id = prio;
        end else begin
            gnt_id = bus.req1_valid;
        end
        bus.req0_ready = gnt_valid && (gnt_id == 1'b0) && !reset;
        bus.req1_ready = gnt_valid && (gnt_id == 1'b1) && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio        <= 1'b0;
            op_id       <= 1'b0;
            op_a        <= '0;
            op_b        <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_s_q     <= '0;
            res_z_q     <= 1'b0;
            res_n_q     <= 1'b0;
            res_p_q     <= 1'b0;
            res_v_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        op_id <= gnt_id;
                        op_a  <= gnt_id ? bus.req1_a : bus.req0_a;
                        op_b  <= gnt_id ? bus.req1_b : bus.req0_b;
                        prio  <= other_req(gnt_id);
                    end
                end
                CALC: begin
                    res_valid_q <= 1'b1;
                    res_id_q    <= op_id;
                    res_s_q     <= sum_s;
                    res_z_q     <= sum_z;
                    res_n_q     <= sum_n;
                    res_p_q     <= sum_p;
                    res_v_q     <= sum_v;
                end
                HOLD: begin
                    // Only valid drops; the data and flags keep their last value.
                    if (bus.res_ready) res_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_id    = res_id_q;
    assign bus.res_s     = res_s_q;
    assign bus.res_z     = res_z_q;
    assign bus.res_n     = res_n_q;
    assign bus.res_p     = res_p_q;
    assign bus.res_v     = res_v_q;

endmodule
